sv_brk_seq: RTL and testbench
=============================

SV_BRK_SEQ -- requirements
Module: sv_brk_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter PDLY SHALL default to 4 and SHALL set the guard cycles between SVMODI and the peripheral stops, range 1..15.
REQ-003 Parameter STBTO SHALL default to 15 and SHALL set the standby-release timeout in cycles, range 1..15.
REQ-004 CLK  input  1  system clock; all state changes on its rising edge.
REQ-005 RST  input  1  synchronous reset, active-high.
REQ-006 BRKREQ  input  1  full break request from the break detectors (level).
REQ-007 OPBRKREQ  input  1  open break request (level).
REQ-008 RUNREQ  input  1  resume request from the emulator (level).
REQ-009 PERI0STPEN  input  1  stop timers during a full break.
REQ-010 PERI1STPEN  input  1  stop serial peripherals during a full break.
REQ-011 STBY  input  1  CPU is in standby (from chip).
REQ-012 SVMODI  output  1  supervisor-mode request to the downstream OR stage.
REQ-013 SVMODIPERI2  output  1  timer stop (SVPERI0 path).
REQ-014 SVMODIPERI1  output  1  serial stop (SVPERI1 path).
REQ-015 SVMODOPBRK  output  1  open-break supervisor request.
REQ-016 STBRELESV  output  1  one-cycle standby-release pulse.
REQ-017 BRKACK  output  1  full break established.
REQ-018 BRKST  output  3  current state code.

Function
REQ-019 The FSM SHALL have these states and codes: RUN=0, STBR=1, ENT=2, BRK=3, PREL=4, OPB=5.
REQ-020 All outputs SHALL be registered, and every output SHALL be decoded from the next state, so each output is valid in the cycle the state is entered.
REQ-021 In RUN, BRKREQ=1 SHALL go to STBR if STBY=1, otherwise to ENT; BRKREQ SHALL take priority over OPBRKREQ and over RUNREQ.
REQ-022 In RUN, OPBRKREQ=1 with BRKREQ=0 SHALL go to OPB.
REQ-023 On entry to STBR, STBRELESV SHALL be 1 for exactly one cycle and the counter SHALL load STBTO.
REQ-024 STBR SHALL go to ENT when STBY=0 or when the counter reaches 0, whichever comes first.
REQ-025 On entry to ENT, the counter SHALL load PDLY, and ENT SHALL last exactly PDLY cycles before going to BRK.
REQ-026 SVMODI SHALL be 1 in STBR, ENT, BRK and PREL, and 0 otherwise.
REQ-027 In BRK, SVMODIPERI2 SHALL equal PERI0STPEN, SVMODIPERI1 SHALL equal PERI1STPEN, and BRKACK SHALL be 1.
REQ-028 The enables SHALL be sampled on each cycle in BRK.
REQ-029 In BRK, RUNREQ=1 with BRKREQ=0 SHALL go to PREL; RUNREQ=1 with BRKREQ=1 SHALL stay in BRK.
REQ-030 PREL SHALL hold SVMODI=1, with the peripheral stops and BRKACK at 0, for exactly PDLY cycles, then SHALL go to RUN.
REQ-031 BRKREQ=1 during PREL SHALL return to BRK immediately.
REQ-032 In OPB, SVMODOPBRK SHALL be 1 and all other outputs SHALL be 0 except BRKST.
REQ-033 In OPB, BRKREQ=1 SHALL escalate to STBR or ENT using the same rule as RUN.
REQ-034 In OPB, RUNREQ=1 or OPBRKREQ=0 SHALL return to RUN.
REQ-035 BRKREQ or OPBRKREQ going low in ENT or STBR SHALL NOT abort the entry sequence.
REQ-036 The counter SHALL be 4 bits, decrement saturating at 0, and never wrap.
REQ-037 Illegal state codes SHALL recover to RUN on the next cycle.

Reset
REQ-038 While RST=1, the state SHALL be RUN, the counter 0, and all outputs 0 (BRKST=0).
REQ-039 Reset asserted mid-sequence (ENT, BRK, PREL) SHALL clear SVMODI and all stops on the next edge, with no PREL delay.
REQ-040 The first request SHALL be sampled on the first edge after RST falls.

Structure
REQ-041 Package sv_brk_pkg SHALL hold the state codes, the default values of PDLY and STBTO, and the counter width.
REQ-042 The load/decrement/zero-flag counter SHALL be one sub-module, sv_brk_dlycnt; the FSM and output decode SHALL live in sv_brk_seq.

Verification
REQ-043 Full break: STBY=0, PERI0STPEN=1, PERI1STPEN=0, BRKREQ pulse at cycle 10 -> SVMODI=1 at cycle 11; BRK at cycle 15 with SVMODIPERI2=1, SVMODIPERI1=0, BRKACK=1.
REQ-044 Resume: RUNREQ at cycle 30 -> PREL at cycle 31 with stops=0 and SVMODI=1; RUN at cycle 35 with SVMODI=0.
REQ-045 Standby: STBY=1, BRKREQ -> STBRELESV=1 for one cycle; STBY drops 3 cycles later -> ENT. STBY held high -> ENT after 15 cycles.
REQ-046 Open break: OPBRKREQ=1 -> SVMODOPBRK=1 and SVMODI=0; BRKREQ then -> SVMODOPBRK=0 and SVMODI=1 (ENT).
REQ-047 Simultaneous events: BRKREQ and RUNREQ together in RUN -> ENT; BRKREQ in the 2nd PREL cycle -> BRK in the next cycle.
REQ-048 Reset in BRK -> all outputs 0 and BRKST=0 on the next edge.

Source files
------------

// File: rtl/sv_brk_pkg.sv
// Shared definitions for the break sequencer: state codes, parameter
// defaults and the guard/timeout counter width.
package sv_brk_pkg;

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned PDLY_DEF  = 4;
    localparam int unsigned STBTO_DEF = 15;

    typedef enum logic [2:0] {
        ST_RUN  = 3'd0,
        ST_STBR = 3'd1,
        ST_ENT  = 3'd2,
        ST_BRK  = 3'd3,
        ST_PREL = 3'd4,
        ST_OPB  = 3'd5
    } brk_state_e;

endpackage

// File: rtl/sv_brk_seq_if.sv
// Break sequencer signal bundle.
// master: emulator/chip side, drives the requests, enables and STBY.
// slave : sequencer side, drives the supervisor requests, BRKACK and BRKST.
interface sv_brk_seq_if;

    logic       BRKREQ;
    logic       OPBRKREQ;
    logic       RUNREQ;
    logic       PERI0STPEN;
    logic       PERI1STPEN;
    logic       STBY;
    logic       SVMODI;
    logic       SVMODIPERI2;
    logic       SVMODIPERI1;
    logic       SVMODOPBRK;
    logic       STBRELESV;
    logic       BRKACK;
    logic [2:0] BRKST;

    modport master (
        output BRKREQ, OPBRKREQ, RUNREQ, PERI0STPEN, PERI1STPEN, STBY,
        input  SVMODI, SVMODIPERI2, SVMODIPERI1, SVMODOPBRK, STBRELESV,
               BRKACK, BRKST
    );

    modport slave (
        input  BRKREQ, OPBRKREQ, RUNREQ, PERI0STPEN, PERI1STPEN, STBY,
        output SVMODI, SVMODIPERI2, SVMODIPERI1, SVMODOPBRK, STBRELESV,
               BRKACK, BRKST
    );

endinterface

// File: rtl/sv_brk_dlycnt.sv
// Guard/timeout counter: loads a value, decrements every cycle when
// enabled and saturates at zero.
// Ports: clk, rst (sync, active-high), load/ld_val, dec,
//        cnt (registered count), zero_c (count is zero).
module sv_brk_dlycnt
    import sv_brk_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] ld_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero_c
);

    // Load has priority; decrement never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= ld_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/sv_brk_seq.sv
// Break sequencer: walks the CPU into and out of supervisor (break) mode,
// with guard delays around the peripheral stops and a standby release.
// Ports: CLK, RST (sync, active-high), bus (sv_brk_seq_if.slave) carrying
//        requests/enables/STBY in and SVMODI, peripheral stops,
//        SVMODOPBRK, STBRELESV, BRKACK, BRKST out.
// All outputs are registered and decoded from the next state.
module sv_brk_seq
    import sv_brk_pkg::*;
#(
    parameter int unsigned PDLY  = PDLY_DEF,
    parameter int unsigned STBTO = STBTO_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    sv_brk_seq_if.slave    bus
);

    brk_state_e       state_q;
    brk_state_e       state_nx;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_ld_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero_c;
    logic             cnt_last;

    sv_brk_dlycnt u_dlycnt (
        .clk    (CLK),
        .rst    (RST),
        .load   (cnt_load),
        .ld_val (cnt_ld_val),
        .dec    (1'b1),
        .cnt    (cnt),
        .zero_c (cnt_zero_c)
    );

    // Counter is loaded on entry, so a state timed by N lasts N cycles when
    // it leaves on the cycle the count reads 1.
    assign cnt_last = cnt_zero_c || (cnt == CNT_W'(1));

    // Next-state logic.
    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_RUN: begin
                if (bus.BRKREQ)        state_nx = bus.STBY ? ST_STBR : ST_ENT;
                else if (bus.OPBRKREQ) state_nx = ST_OPB;
            end
            ST_STBR: begin
                if (!bus.STBY || cnt_last) state_nx = ST_ENT;
            end
            ST_ENT: begin
                if (cnt_last) state_nx = ST_BRK;
            end
            ST_BRK: begin
                if (bus.RUNREQ && !bus.BRKREQ) state_nx = ST_PREL;
            end
            ST_PREL: begin
                if (bus.BRKREQ)    state_nx = ST_BRK;
                else if (cnt_last) state_nx = ST_RUN;
            end
            ST_OPB: begin
                if (bus.BRKREQ)                          state_nx = bus.STBY ? ST_STBR : ST_ENT;
                else if (bus.RUNREQ || !bus.OPBRKREQ)    state_nx = ST_RUN;
            end
            default: state_nx = ST_RUN;
        endcase
    end

    // Counter load on entry to a timed state.
    always_comb begin
        cnt_load   = (state_nx != state_q) &&
                     ((state_nx == ST_STBR) || (state_nx == ST_ENT) || (state_nx == ST_PREL));
        cnt_ld_val = (state_nx == ST_STBR) ? CNT_W'(STBTO) : CNT_W'(PDLY);
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= ST_RUN;
            bus.SVMODI      <= 1'b0;
            bus.SVMODIPERI2 <= 1'b0;
            bus.SVMODIPERI1 <= 1'b0;
            bus.SVMODOPBRK  <= 1'b0;
            bus.STBRELESV   <= 1'b0;
            bus.BRKACK      <= 1'b0;
            bus.BRKST       <= 3'd0;
        end else begin
            state_q         <= state_nx;
            bus.SVMODI      <= (state_nx == ST_STBR) || (state_nx == ST_ENT) ||
                               (state_nx == ST_BRK)  || (state_nx == ST_PREL);
            bus.SVMODIPERI2 <= (state_nx == ST_BRK) && bus.PERI0STPEN;
            bus.SVMODIPERI1 <= (state_nx == ST_BRK) && bus.PERI1STPEN;
            bus.SVMODOPBRK  <= (state_nx == ST_OPB);
            bus.STBRELESV   <= (state_nx == ST_STBR) && (state_q != ST_STBR);
            bus.BRKACK      <= (state_nx == ST_BRK);
            bus.BRKST       <= state_nx;
        end
    end

endmodule

// File: tb/tb_sv_brk_seq.sv
// Directed bench for sv_brk_seq with default PDLY=4, STBTO=15.
// Outputs are packed as {SVMODI,PERI2,PERI1,OPBRK,STBRELESV,BRKACK,BRKST}.
module tb_sv_brk_seq;

    logic CLK;
    logic RST;
    int   n_chk;
    int   n_pass;

    sv_brk_seq_if bus ();

    sv_brk_seq dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    localparam logic [8:0] E_RUN   = 9'b0_0_0_0_0_0_000;
    localparam logic [8:0] E_STBR1 = 9'b1_0_0_0_1_0_001;
    localparam logic [8:0] E_STBR  = 9'b1_0_0_0_0_0_001;
    localparam logic [8:0] E_ENT   = 9'b1_0_0_0_0_0_010;
    localparam logic [8:0] E_BRK10 = 9'b1_1_0_0_0_1_011;
    localparam logic [8:0] E_BRK01 = 9'b1_0_1_0_0_1_011;
    localparam logic [8:0] E_BRK00 = 9'b1_0_0_0_0_1_011;
    localparam logic [8:0] E_PREL  = 9'b1_0_0_0_0_0_100;
    localparam logic [8:0] E_OPB   = 9'b0_0_0_1_0_0_101;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [8:0] outs();
        return {bus.SVMODI, bus.SVMODIPERI2, bus.SVMODIPERI1, bus.SVMODOPBRK,
                bus.STBRELESV, bus.BRKACK, bus.BRKST};
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        RST = 1'b1;
        bus.BRKREQ = 1'b1; bus.OPBRKREQ = 1'b0; bus.RUNREQ = 1'b0;
        bus.PERI0STPEN = 1'b1; bus.PERI1STPEN = 1'b0; bus.STBY = 1'b0;
        step(2);
        check("reset_hold", outs(), E_RUN);

        // Full break; request present on the first edge after reset release.
        RST = 1'b0;
        step(1);  check("ent_first", outs(), E_ENT);
        bus.BRKREQ = 1'b0;
        step(3);  check("ent_last", outs(), E_ENT);
        step(1);  check("brk_p0", outs(), E_BRK10);
        bus.PERI0STPEN = 1'b0; bus.PERI1STPEN = 1'b1;
        step(1);  check("brk_p1", outs(), E_BRK01);

        // Resume through PREL.
        bus.RUNREQ = 1'b1;
        step(1);  check("prel_first", outs(), E_PREL);
        bus.RUNREQ = 1'b0;
        step(3);  check("prel_last", outs(), E_PREL);
        step(1);  check("run_after_prel", outs(), E_RUN);

        // BRKREQ with RUNREQ in RUN; then re-break in 2nd PREL cycle.
        bus.PERI1STPEN = 1'b0;
        bus.BRKREQ = 1'b1; bus.RUNREQ = 1'b1;
        step(1);  check("brk_over_run", outs(), E_ENT);
        bus.BRKREQ = 1'b0; bus.RUNREQ = 1'b0;
        step(4);  check("brk_again", outs(), E_BRK00);
        bus.RUNREQ = 1'b1;
        step(1);  check("prel_c1", outs(), E_PREL);
        bus.RUNREQ = 1'b0;
        step(1);  check("prel_c2", outs(), E_PREL);
        bus.BRKREQ = 1'b1;
        step(1);  check("prel_rebrk", outs(), E_BRK00);
        bus.RUNREQ = 1'b1;
        step(1);  check("brk_hold_both", outs(), E_BRK00);

        // Reset mid-break clears everything on the next edge.
        bus.PERI0STPEN = 1'b1;
        RST = 1'b1;
        step(1);  check("reset_in_brk", outs(), E_RUN);
        bus.BRKREQ = 1'b0; bus.RUNREQ = 1'b0; bus.PERI0STPEN = 1'b0;
        RST = 1'b0;
        step(1);  check("idle_after_rst", outs(), E_RUN);

        // Standby: STBY drops in the 3rd STBR cycle.
        bus.STBY = 1'b1; bus.BRKREQ = 1'b1;
        step(1);  check("stbr_pulse", outs(), E_STBR1);
        bus.BRKREQ = 1'b0;
        step(1);  check("stbr_c2", outs(), E_STBR);
        step(1);  check("stbr_c3", outs(), E_STBR);
        bus.STBY = 1'b0;
        step(1);  check("stbr_to_ent", outs(), E_ENT);
        step(4);  check("stbr_brk", outs(), E_BRK00);
        bus.RUNREQ = 1'b1;
        step(1);  bus.RUNREQ = 1'b0;
        step(4);  check("stbr_run", outs(), E_RUN);

        // Standby timeout: STBY held high for all 15 STBR cycles.
        bus.STBY = 1'b1; bus.BRKREQ = 1'b1;
        step(1);  bus.BRKREQ = 1'b0;
        step(14); check("stbto_last", outs(), E_STBR);
        step(1);  check("stbto_ent", outs(), E_ENT);
        bus.STBY = 1'b0;
        step(4);  bus.RUNREQ = 1'b1;
        step(1);  bus.RUNREQ = 1'b0;
        step(4);  check("stbto_run", outs(), E_RUN);

        // Open break, then escalation; dropping requests in ENT must not abort.
        bus.OPBRKREQ = 1'b1;
        step(1);  check("opb_enter", outs(), E_OPB);
        step(1);  check("opb_hold", outs(), E_OPB);
        bus.BRKREQ = 1'b1;
        step(1);  check("opb_escalate", outs(), E_ENT);
        bus.BRKREQ = 1'b0; bus.OPBRKREQ = 1'b0;
        step(3);  check("ent_no_abort", outs(), E_ENT);
        step(1);  check("opb_brk", outs(), E_BRK00);
        bus.RUNREQ = 1'b1;
        step(1);  bus.RUNREQ = 1'b0;
        step(4);  check("opb_brk_run", outs(), E_RUN);

        // OPB exits: OPBRKREQ low, and RUNREQ.
        bus.OPBRKREQ = 1'b1;
        step(1);  bus.OPBRKREQ = 1'b0;
        step(1);  check("opb_drop", outs(), E_RUN);
        bus.OPBRKREQ = 1'b1;
        step(1);  bus.RUNREQ = 1'b1;
        step(1);  check("opb_runreq", outs(), E_RUN);
        bus.RUNREQ = 1'b0; bus.OPBRKREQ = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
